// File: rtl/dwc_frame_arbiter.sv
// dwc_frame_arbiter: frame-granular round-robin arbiter sharing one dwc input between N streams
// Optional stall-timeout abort is compiled in with `define DWC_ARB_TIMEOUT_EN
module dwc_frame_arbiter #(
    parameter int N         = 4,
    parameter int IBITS     = 8,
    parameter int FRAME_LEN = 16,
    parameter int TIMEOUT   = 64,
    localparam int IDW      = (N > 1) ? $clog2(N) : 1,
    localparam int CW       = $clog2(FRAME_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       ivld,
    output logic [N-1:0]       irdy,
    input  logic [N*IBITS-1:0] idat,
    output logic               ovld,
    input  logic               ordy,
    output logic [IBITS-1:0]   odat,
    output logic [IDW-1:0]     oid,
    output logic               olast,
    output logic               oabort
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] gnt_q, gnt_d, last_q, last_d, pick, idx;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           found, beat, abort;

    if (N < 1 || FRAME_LEN < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("dwc_frame_arbiter: N, FRAME_LEN and TIMEOUT must all be >= 1");
    end

`ifdef DWC_ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0] stall_q, stall_d;
`endif

    // Round-robin pick: first valid requester after the last one served
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IDW'((32'(last_q) + k) % N);
            if (!found && ivld[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Next-state and pass-through datapath: grant is held for a whole frame
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        irdy    = '0;
        ovld    = 1'b0;
        olast   = 1'b0;
        beat    = 1'b0;
        abort   = 1'b0;
        odat    = idat[32'(gnt_q)*IBITS +: IBITS];
        oid     = gnt_q;
`ifdef DWC_ARB_TIMEOUT_EN
        stall_d = '0;
`endif
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (found) begin
                gnt_d   = pick;
                state_d = BURST;
            end
        end else begin
            ovld        = ivld[gnt_q];
            irdy[gnt_q] = ordy;
            olast       = ovld && (cnt_q == CW'(FRAME_LEN - 1));
            beat        = ovld && ordy;
`ifdef DWC_ARB_TIMEOUT_EN
            abort   = !ivld[gnt_q] && (stall_q == SW'(TIMEOUT - 1));
            stall_d = ivld[gnt_q] ? '0 : stall_q + 1'b1;
`endif
            if (beat) begin
                cnt_d = cnt_q + 1'b1;
                if (olast) begin
                    cnt_d   = '0;
                    last_d  = gnt_q;
                    state_d = IDLE;
                end
            end else if (abort) begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
        end
        oabort = abort;
    end

    // State registers; last starts at N-1 so requester 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IDW'(N - 1);
            cnt_q   <= '0;
`ifdef DWC_ARB_TIMEOUT_EN
            stall_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
`ifdef DWC_ARB_TIMEOUT_EN
            stall_q <= stall_d;
`endif
        end
    end
endmodule

// File: tb/tb_dwc_frame_arbiter.sv
// tb_dwc_frame_arbiter: randomized self-checking bench against a behavioural frame-arbiter model
module tb_dwc_frame_arbiter;
    localparam int N   = 4;
    localparam int IB  = 8;
    localparam int FL  = 4;
    localparam int TO  = 5;
    localparam int IDW = 2;
    localparam int VW  = N + 1 + IB + IDW + 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    ivld = '0;
    logic [N-1:0]    irdy;
    logic [N*IB-1:0] idat = '0;
    logic            ovld;
    logic            ordy = 1'b0;
    logic [IB-1:0]   odat;
    logic [IDW-1:0]  oid;
    logic            olast;
    logic            oabort;

    int checks = 0;
    int passed = 0;

    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_done  = 0;
    int m_last  = N - 1;
    int m_stall = 0;

    dwc_frame_arbiter #(.N(N), .IBITS(IB), .FRAME_LEN(FL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ivld(ivld), .irdy(irdy), .idat(idat),
        .ovld(ovld), .ordy(ordy), .odat(odat), .oid(oid), .olast(olast), .oabort(oabort)
    );

    always #5 clk = ~clk;

    function automatic bit timeout_on();
`ifdef DWC_ARB_TIMEOUT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0] r;
        logic v, l, a;
        r = '0;
        v = 1'b0;
        l = 1'b0;
        a = 1'b0;
        if (m_busy) begin
            v = ivld[m_owner];
            r[m_owner] = ordy;
            l = v && (m_done == FL - 1);
            a = timeout_on() && !ivld[m_owner] && (m_stall == TO - 1);
        end
        return {r, v, idat[m_owner*IB +: IB], IDW'(m_owner), l, a};
    endfunction

    task automatic step_model();
        bit b, a, f;
        int c;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_done = 0; m_last = N - 1; m_stall = 0;
        end else if (!m_busy) begin
            f = 0;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!f && ivld[c]) begin
                    f = 1; m_owner = c;
                end
            end
            if (f) begin
                m_busy = 1; m_done = 0; m_stall = 0;
            end
        end else begin
            b = ivld[m_owner] && ordy;
            a = timeout_on() && !ivld[m_owner] && (m_stall == TO - 1);
            if (b) begin
                m_done++;
                if (m_done == FL) begin
                    m_busy = 0; m_last = m_owner;
                end
            end else if (a) begin
                m_busy = 0; m_last = m_owner;
            end
            m_stall = ivld[m_owner] ? 0 : m_stall + 1;
        end
    endtask

    task automatic clock_model();
        @(posedge clk);
        step_model();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ivld = '0;
        ordy = 1'b0;
        clock_model();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({irdy, ovld, odat, oid, olast, oabort} !== exp_vec() || {irdy, ovld, oid, olast, oabort} !== '0)
                $display("FAIL reset_idle cyc %0d got %h exp %h", c, {irdy, ovld, odat, oid, olast, oabort}, exp_vec());
            else passed++;
            clock_model();
        end
    endtask

    task automatic test_single_stream();
        int beats = 0;
        ivld = 4'b0100;
        ordy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            idat = $urandom;
            @(negedge clk);
            checks++;
            if ({irdy, ovld, odat, oid, olast, oabort} !== exp_vec())
                $display("FAIL single cyc %0d got %h exp %h", c, {irdy, ovld, odat, oid, olast, oabort}, exp_vec());
            else passed++;
            if (ovld && ordy) beats++;
            clock_model();
        end
        checks++;
        if (beats !== 8) $display("FAIL single_beats got %0d exp 8", beats);
        else passed++;
    endtask

    task automatic test_round_robin();
        int ids[$];
        do_reset();
        ivld = '1;
        ordy = 1'b1;
        for (int c = 0; c < 5 * (FL + 1); c++) begin
            idat = $urandom;
            @(negedge clk);
            checks++;
            if ({irdy, ovld, odat, oid, olast, oabort} !== exp_vec())
                $display("FAIL rr cyc %0d got %h exp %h", c, {irdy, ovld, odat, oid, olast, oabort}, exp_vec());
            else passed++;
            if (olast && ordy) ids.push_back(int'(oid));
            clock_model();
        end
        checks++;
        if (ids.size() !== 5) $display("FAIL rr_frames got %0d exp 5", ids.size());
        else begin
            passed++;
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (ids[k] !== k % N) $display("FAIL rr_order frame %0d got %0d exp %0d", k, ids[k], k % N);
                else passed++;
            end
        end
    endtask

    task automatic test_ordy_toggle();
        int acc = 0;
        int last_at = -1;
        do_reset();
        ivld = 4'b0010;
        idat = $urandom;
        for (int c = 0; c < 9; c++) begin
            ordy = (c % 2 == 1);
            @(negedge clk);
            checks++;
            if ({irdy, ovld, odat, oid, olast, oabort} !== exp_vec())
                $display("FAIL ordy_toggle cyc %0d got %h exp %h", c, {irdy, ovld, odat, oid, olast, oabort}, exp_vec());
            else passed++;
            if (ovld && ordy) begin
                acc++;
                if (olast) last_at = acc;
            end
            clock_model();
            if (ordy) idat = $urandom;
        end
        checks++;
        if (last_at !== FL) $display("FAIL ordy_last_beat got %0d exp %0d", last_at, FL);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        ivld = 4'b1000;
        ordy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            idat = $urandom;
            if (c == 3) rst = 1'b1;
            @(negedge clk);
            checks++;
            if ({irdy, ovld, odat, oid, olast, oabort} !== exp_vec())
                $display("FAIL reset_mid cyc %0d got %h exp %h", c, {irdy, ovld, odat, oid, olast, oabort}, exp_vec());
            else passed++;
            clock_model();
        end
        rst = 1'b0;
        ivld = '1;
        @(negedge clk);
        checks++;
        if ({irdy, ovld, oid, olast, oabort} !== '0 || {irdy, ovld, odat, oid, olast, oabort} !== exp_vec())
            $display("FAIL reset_mid_after got %h exp %h", {irdy, ovld, odat, oid, olast, oabort}, exp_vec());
        else passed++;
        clock_model();
        @(negedge clk);
        checks++;
        if (oid !== 0 || ovld !== 1'b1) $display("FAIL reset_mid_regrant got oid %0d ovld %0b exp oid 0 ovld 1", oid, ovld);
        else passed++;
        clock_model();
    endtask

    task automatic test_stall();
        int abort_at = -1;
        int oid7 = -1;
        bit saw_last = 0;
        do_reset();
        ivld = 4'b0011;
        ordy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c == 2) ivld = 4'b0010;
            idat = $urandom;
            @(negedge clk);
            checks++;
            if ({irdy, ovld, odat, oid, olast, oabort} !== exp_vec())
                $display("FAIL stall cyc %0d got %h exp %h", c, {irdy, ovld, odat, oid, olast, oabort}, exp_vec());
            else passed++;
            if (oabort && abort_at < 0) abort_at = c - 2;
            if (olast && oid == 0) saw_last = 1;
            if (c == 8) oid7 = int'(oid);
            clock_model();
        end
        checks++;
        if (saw_last) $display("FAIL stall_olast got 1 exp 0");
        else passed++;
        checks++;
        if (timeout_on() ? (abort_at !== TO - 1 || oid7 !== 1) : (abort_at !== -1 || oid7 !== 0))
            $display("FAIL stall_outcome got abort_at %0d oid %0d", abort_at, oid7);
        else passed++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            ivld = N'($urandom);
            ordy = 1'($urandom);
            idat = $urandom;
            @(negedge clk);
            checks++;
            if ({irdy, ovld, odat, oid, olast, oabort} !== exp_vec())
                $display("FAIL random cyc %0d got %h exp %h", c, {irdy, ovld, odat, oid, olast, oabort}, exp_vec());
            else passed++;
            clock_model();
        end
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_round_robin();
        test_ordy_toggle();
        test_reset_mid();
        test_stall();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
